// File: rtl/ipg_pkg.sv
// ipg_pkg: shared 64b/66b constants and types for IPG payload insertion and extraction
package ipg_pkg;
    localparam logic [1:0] SYNC_DATA = 2'b10;
    localparam logic [1:0] SYNC_CTRL = 2'b01;
    localparam int IPG_PAYLOAD_W = 56;
    localparam logic [63:0] IDLE_BLOCK = 64'h1e;
    localparam logic [7:0] BLOCK_TYPE_IDLE  = 8'h1e;
    localparam logic [7:0] BLOCK_TYPE_REQ   = 8'h1a;
    localparam logic [7:0] BLOCK_TYPE_RESP  = 8'h1f;
    localparam logic [7:0] BLOCK_TYPE_C_O   = 8'h2d;
    localparam logic [7:0] BLOCK_TYPE_C_S4  = 8'h33;
    localparam logic [7:0] BLOCK_TYPE_O_S4  = 8'h66;
    localparam logic [7:0] BLOCK_TYPE_O_O   = 8'h55;
    localparam logic [7:0] BLOCK_TYPE_S0    = 8'h78;
    localparam logic [7:0] BLOCK_TYPE_O0    = 8'h4b;
    localparam logic [7:0] BLOCK_TYPE_T0    = 8'h87;
    localparam logic [7:0] BLOCK_TYPE_T1    = 8'h99;
    localparam logic [7:0] BLOCK_TYPE_T2    = 8'haa;
    localparam logic [7:0] BLOCK_TYPE_T3    = 8'hb4;
    localparam logic [7:0] BLOCK_TYPE_T4    = 8'hcc;
    localparam logic [7:0] BLOCK_TYPE_T5    = 8'hd2;
    localparam logic [7:0] BLOCK_TYPE_T6    = 8'he1;
    localparam logic [7:0] BLOCK_TYPE_T7    = 8'hff;

    typedef enum logic {
        ST_IDLE,
        ST_FRAME
    } frame_state_t;

    function automatic logic is_start(input logic [7:0] t);
        return t == BLOCK_TYPE_S0 || t == BLOCK_TYPE_C_S4 || t == BLOCK_TYPE_O_S4;
    endfunction

    function automatic logic is_term(input logic [7:0] t);
        return t == BLOCK_TYPE_T0 || t == BLOCK_TYPE_T1 || t == BLOCK_TYPE_T2 ||
               t == BLOCK_TYPE_T3 || t == BLOCK_TYPE_T4 || t == BLOCK_TYPE_T5 ||
               t == BLOCK_TYPE_T6 || t == BLOCK_TYPE_T7;
    endfunction
endpackage

// File: rtl/ipg_req_fifo.sv
// ipg_req_fifo: synchronous request payload FIFO with registered pointers and occupancy level
//   clk, rst       : clock, synchronous active-high reset
//   push/push_data : write one payload (ignored when full)
//   pop            : drop the head entry (ignored when empty)
//   head           : current head payload, valid when !empty
//   empty/full     : occupancy flags
//   level          : number of stored entries
module ipg_req_fifo
    import ipg_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [IPG_PAYLOAD_W-1:0] push_data,
    input  logic                     pop,
    output logic [IPG_PAYLOAD_W-1:0] head,
    output logic                     empty,
    output logic                     full,
    output logic [4:0]               level
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [IPG_PAYLOAD_W-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;

    assign empty   = level == 5'd0;
    assign full    = level == 5'(DEPTH);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            level <= level + 5'(do_push) - 5'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/ipg_tx_insert.sv
// ipg_tx_insert: substitutes pending request/response payloads into inter-packet idle blocks
//   clk, rst                         : clock, synchronous active-high reset
//   ipg_en                           : 1 = insertion enabled, 0 = registered pass-through
//   encoded_tx_hdr/encoded_tx_data   : 66-bit block from the encoder
//   req_data/req_valid/req_ready     : request payload stream into the request FIFO
//   resp_data/resp_valid/resp_ready  : response payload into the single holding register
//   ipg_tx_hdr/ipg_tx_data           : registered block towards the scrambler
//   req_sent_cnt/resp_sent_cnt       : wrapping counts of inserted REQ/RESP blocks
//   fifo_level                       : request FIFO occupancy
module ipg_tx_insert
    import ipg_pkg::*;
#(
    parameter int REQ_FIFO_DEPTH = 4,
    parameter int CNT_W          = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ipg_en,
    input  logic [1:0]               encoded_tx_hdr,
    input  logic [63:0]              encoded_tx_data,
    input  logic [IPG_PAYLOAD_W-1:0] req_data,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [IPG_PAYLOAD_W-1:0] resp_data,
    input  logic                     resp_valid,
    output logic                     resp_ready,
    output logic [1:0]               ipg_tx_hdr,
    output logic [63:0]              ipg_tx_data,
    output logic [CNT_W-1:0]         req_sent_cnt,
    output logic [CNT_W-1:0]         resp_sent_cnt,
    output logic [4:0]               fifo_level
);
    frame_state_t state, state_next;
    logic [IPG_PAYLOAD_W-1:0] resp_buf, fifo_head;
    logic resp_pending, fifo_empty, fifo_full;
    logic is_ctrl, idle_blk, eligible, sel_resp, sel_req;
    logic [7:0] blk_type;
    logic [63:0] data_next;

    assign req_ready  = !rst && !fifo_full;
    assign resp_ready = !rst && !resp_pending;

    ipg_req_fifo #(
        .DEPTH(REQ_FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (req_valid && req_ready),
        .push_data(req_data),
        .pop      (sel_req),
        .head     (fifo_head),
        .empty    (fifo_empty),
        .full     (fifo_full),
        .level    (fifo_level)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else state <= state_next;
    end

    // An idle block arriving mid-frame closes the frame, so eligibility
    // looks at the state after this block's transition.
    always_comb begin
        blk_type   = encoded_tx_data[7:0];
        is_ctrl    = encoded_tx_hdr == SYNC_CTRL;
        state_next = state;
        if (is_ctrl && state == ST_IDLE && is_start(blk_type))
            state_next = ST_FRAME;
        else if (is_ctrl && state == ST_FRAME && (is_term(blk_type) || blk_type == BLOCK_TYPE_IDLE))
            state_next = ST_IDLE;
        idle_blk  = is_ctrl && encoded_tx_data == IDLE_BLOCK;
        eligible  = ipg_en && idle_blk && state_next == ST_IDLE;
        sel_resp  = eligible && resp_pending;
        sel_req   = eligible && !resp_pending && !fifo_empty;
        data_next = sel_resp ? {resp_buf, BLOCK_TYPE_RESP} :
                    sel_req  ? {fifo_head, BLOCK_TYPE_REQ} : encoded_tx_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ipg_tx_hdr    <= SYNC_CTRL;
            ipg_tx_data   <= IDLE_BLOCK;
            req_sent_cnt  <= '0;
            resp_sent_cnt <= '0;
        end else begin
            ipg_tx_hdr  <= encoded_tx_hdr;
            ipg_tx_data <= data_next;
            if (sel_req) req_sent_cnt <= req_sent_cnt + 1'b1;
            if (sel_resp) resp_sent_cnt <= resp_sent_cnt + 1'b1;
        end
    end

    // Loading needs resp_ready (register empty) and clearing needs a pending
    // entry, so both never happen in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_pending <= 1'b0;
            resp_buf     <= '0;
        end else if (resp_valid && resp_ready) begin
            resp_pending <= 1'b1;
            resp_buf     <= resp_data;
        end else if (sel_resp) begin
            resp_pending <= 1'b0;
        end
    end
endmodule
